// File: rtl/pkt_rr_arb.sv
// Packet-atomic round-robin arbiter: merges NUM_IN sop/eop beat streams onto one
// registered output stream, holding each grant from sop to eop under almost_full backpressure.
module pkt_rr_arb #(
  parameter int unsigned NUM_IN  = 4,
  parameter int unsigned DATA_W  = 512,
  parameter int unsigned EMPTY_W = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_IN-1:0]         in_sop,
  input  logic [NUM_IN-1:0]         in_eop,
  input  logic [NUM_IN*DATA_W-1:0]  in_data,
  input  logic [NUM_IN*EMPTY_W-1:0] in_empty,
  input  logic [NUM_IN-1:0]         in_valid,
  output logic [NUM_IN-1:0]         in_ready,
  output logic                      out_sop,
  output logic                      out_eop,
  output logic [DATA_W-1:0]         out_data,
  output logic [EMPTY_W-1:0]        out_empty,
  output logic                      out_valid,
  input  logic                      out_almost_full,
  output logic [31:0]               pkt_cnt,
  output logic [31:0]               err_cnt
);

  localparam int unsigned GW = $clog2(NUM_IN);

  typedef enum logic {IDLE, XFER} state_t;

  state_t              state, state_nxt;
  logic [GW-1:0]       grant, grant_nxt, last_grant, last_grant_nxt, pick;
  logic [NUM_IN-1:0]   eligible, junk;
  logic                found, accept;
  logic [DATA_W-1:0]   sel_data;
  logic [EMPTY_W-1:0]  sel_empty;
  logic                sel_sop, sel_eop, sel_valid;
  logic [31:0]         err_inc;

  assign eligible = in_valid & in_sop;
  assign junk     = in_valid & ~in_sop;

  always_comb begin
    sel_data  = '0;
    sel_empty = '0;
    sel_sop   = 1'b0;
    sel_eop   = 1'b0;
    sel_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (GW'(i) == grant) begin
        sel_data  = in_data[i*DATA_W +: DATA_W];
        sel_empty = in_empty[i*EMPTY_W +: EMPTY_W];
        sel_sop   = in_sop[i];
        sel_eop   = in_eop[i];
        sel_valid = in_valid[i];
      end
    end
  end

  // First eligible port at or after last_grant+1, wrapping modulo NUM_IN.
  always_comb begin
    int unsigned idx;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 1; k <= NUM_IN; k++) begin
      idx = (32'(last_grant) + k) % NUM_IN;
      if (!found && eligible[GW'(idx)]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    in_ready       = '0;
    accept         = 1'b0;
    err_inc        = '0;
    case (state)
      IDLE: begin
        // Beats without sop outside a packet are consumed and dropped.
        in_ready = junk;
        for (int unsigned i = 0; i < NUM_IN; i++)
          err_inc = err_inc + 32'(junk[i]);
        if (!out_almost_full && found) begin
          grant_nxt = pick;
          state_nxt = XFER;
        end
      end
      XFER: begin
        for (int unsigned i = 0; i < NUM_IN; i++)
          if (GW'(i) == grant) in_ready[i] = !out_almost_full;
        accept = sel_valid && !out_almost_full;
        if (accept && sel_eop) begin
          last_grant_nxt = grant;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) in_ready = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_IN - 1);
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_data   <= '0;
      out_empty  <= '0;
      pkt_cnt    <= '0;
      err_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      out_valid  <= accept;
      if (accept) begin
        out_sop   <= sel_sop;
        out_eop   <= sel_eop;
        out_data  <= sel_data;
        out_empty <= sel_empty;
      end
      if (accept && sel_eop) pkt_cnt <= pkt_cnt + 32'd1;
      err_cnt <= err_cnt + err_inc;
    end
  end

endmodule

// File: tb/tb_pkt_rr_arb.sv
// Bench for pkt_rr_arb: per-port source queues, packet-level round-robin reference
// model producing the expected output beat order, directed steps then randomized traffic.
module tb_pkt_rr_arb;

  localparam int NUM_IN  = 4;
  localparam int DATA_W  = 512;
  localparam int EMPTY_W = 6;

  typedef struct {
    logic               sop;
    logic               eop;
    logic [DATA_W-1:0]  data;
    logic [EMPTY_W-1:0] empty;
  } beat_t;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_IN-1:0]         in_sop, in_eop, in_valid, in_ready;
  logic [NUM_IN*DATA_W-1:0]  in_data;
  logic [NUM_IN*EMPTY_W-1:0] in_empty;
  logic                      out_sop, out_eop, out_valid, afull;
  logic [DATA_W-1:0]         out_data;
  logic [EMPTY_W-1:0]        out_empty;
  logic [31:0]               pkt_cnt, err_cnt;

  pkt_rr_arb #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .EMPTY_W(EMPTY_W)) dut (
    .clk(clk), .rst(rst),
    .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data), .in_empty(in_empty),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_sop(out_sop), .out_eop(out_eop), .out_data(out_data), .out_empty(out_empty),
    .out_valid(out_valid), .out_almost_full(afull),
    .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int    tests = 0, fails = 0;
  int    cyc = 0, first_out = -1, last_out = -1, model_last = NUM_IN - 1;
  bit    rand_mode = 1'b0, prev_afull = 1'b0;
  beat_t srcq [NUM_IN][$];
  beat_t exp_q[$];

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] d;
    d = '0;
    for (int w = 0; w < DATA_W / 32; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic int pending_beats();
    int n = 0;
    for (int i = 0; i < NUM_IN; i++) n += srcq[i].size();
    return n;
  endfunction

  task automatic drive();
    beat_t h;
    for (int i = 0; i < NUM_IN; i++) begin
      if (srcq[i].size() > 0) begin
        h = srcq[i][0];
        in_valid[i] = h.sop || !rand_mode || ($urandom_range(0, 3) != 0);
        in_sop[i]   = h.sop;
        in_eop[i]   = h.eop;
        in_data[i*DATA_W +: DATA_W]    = h.data;
        in_empty[i*EMPTY_W +: EMPTY_W] = h.empty;
      end else begin
        in_valid[i] = 1'b0;
        in_sop[i]   = 1'b0;
        in_eop[i]   = 1'b0;
      end
    end
    if (rand_mode) afull = ($urandom_range(0, 4) == 0);
  endtask

  // One clock: sample/check at negedge, pop accepted beats and drive new ones after posedge.
  task automatic step();
    logic [NUM_IN-1:0] acc, junk;
    beat_t e;
    @(negedge clk);
    acc  = in_valid & in_ready;
    junk = in_valid & ~in_sop;
    if (!rst) begin
      if (out_valid) begin
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
      if (exp_q.size() == 0) chk("idle_out", DATA_W'(out_valid), '0);
      else if (out_valid) begin
        e = exp_q.pop_front();
        chk("out_sop",   DATA_W'(out_sop),   DATA_W'(e.sop));
        chk("out_eop",   DATA_W'(out_eop),   DATA_W'(e.eop));
        chk("out_data",  out_data,           e.data);
        chk("out_empty", DATA_W'(out_empty), DATA_W'(e.empty));
      end
      if (prev_afull) chk("stall_valid", DATA_W'(out_valid), '0);
      if (afull) chk("stall_ready", DATA_W'(in_ready & ~junk), '0);
      chk("one_accept", DATA_W'($onehot0(acc & ~junk)), DATA_W'(1));
    end
    prev_afull = afull;
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < NUM_IN; i++)
      if (acc[i]) void'(srcq[i].pop_front());
    drive();
  endtask

  // Packet-level reference: leading non-sop beats are dropped, then whole packets
  // are taken round-robin from the port after the last one served.
  task automatic model_load();
    beat_t mq [NUM_IN][$];
    beat_t e;
    int p, q;
    for (int i = 0; i < NUM_IN; i++) mq[i] = srcq[i];
    while (1) begin
      for (int i = 0; i < NUM_IN; i++)
        while (mq[i].size() > 0 && !mq[i][0].sop) void'(mq[i].pop_front());
      p = -1;
      for (int k = 1; k <= NUM_IN; k++) begin
        q = (model_last + k) % NUM_IN;
        if (p < 0 && mq[q].size() > 0) p = q;
      end
      if (p < 0) break;
      do begin
        e = mq[p].pop_front();
        exp_q.push_back(e);
      end while (!e.eop && mq[p].size() > 0);
      model_last = p;
    end
  endtask

  task automatic push_pkt(input int port, input int n, input logic [31:0] base, input logic [EMPTY_W-1:0] emp);
    beat_t b;
    for (int j = 0; j < n; j++) begin
      b.sop   = (j == 0);
      b.eop   = (j == n - 1);
      b.data  = DATA_W'(base) + DATA_W'(j);
      b.empty = b.eop ? emp : '0;
      srcq[port].push_back(b);
    end
  endtask

  task automatic push_rand_pkt(input int port);
    beat_t b;
    int n = $urandom_range(1, 5);
    for (int j = 0; j < n; j++) begin
      b.sop   = (j == 0);
      b.eop   = (j == n - 1);
      b.data  = rand_data();
      b.empty = b.eop ? EMPTY_W'($urandom) : '0;
      srcq[port].push_back(b);
    end
  endtask

  task automatic push_junk(input int port);
    beat_t b;
    b.sop = 1'b0; b.eop = 1'b0; b.data = rand_data(); b.empty = '0;
    srcq[port].push_back(b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NUM_IN; i++) srcq[i].delete();
    exp_q.delete();
    drive();
    step();
    step();
    rst = 1'b0;
    model_last = NUM_IN - 1;
    prev_afull = 1'b0;
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    chk("rst_out_valid", DATA_W'(out_valid), '0);
    chk("rst_out_sop",   DATA_W'(out_sop),   '0);
    chk("rst_out_eop",   DATA_W'(out_eop),   '0);
    chk("rst_out_data",  out_data,           '0);
    chk("rst_out_empty", DATA_W'(out_empty), '0);
    chk("rst_in_ready",  DATA_W'(in_ready),  '0);
    chk("rst_pkt_cnt",   DATA_W'(pkt_cnt),   '0);
    chk("rst_err_cnt",   DATA_W'(err_cnt),   '0);
    @(posedge clk);
    cyc++;
    #1;
    drive();
  endtask

  task automatic run(input int max);
    int n = 0;
    while ((exp_q.size() > 0 || pending_beats() > 0) && n < max) begin
      step();
      n++;
    end
    chk("drain", DATA_W'(exp_q.size() + pending_beats()), '0);
    repeat (3) step();
  endtask

  initial begin
    int start, n, total;
    rst = 1'b1; afull = 1'b0;
    in_valid = '0; in_sop = '0; in_eop = '0; in_data = '0; in_empty = '0;
    @(posedge clk);
    #1;

    do_reset();
    check_reset_state();

    // Single 3-beat packet on port 0: A1/A2/A3, empty=4 on eop.
    push_pkt(0, 3, 32'hA1, 6'd4);
    model_load();
    drive();
    start = cyc;
    first_out = -1;
    run(50);
    chk("first_latency", DATA_W'(first_out - start), DATA_W'(2));
    chk("pkt_cnt_single", DATA_W'(pkt_cnt), DATA_W'(1));

    // All four ports with two back-to-back 2-beat packets each.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NUM_IN; p++) push_pkt(p, 2, 32'h100 + 32'(p * 16 + r * 4), 6'(p + 1));
    model_load();
    drive();
    first_out = -1;
    run(100);
    chk("rr_span", DATA_W'(last_out - first_out), DATA_W'(22));
    chk("pkt_cnt_rr", DATA_W'(pkt_cnt), DATA_W'(8));

    // Five-cycle almost_full stall in the middle of a port 2 packet.
    do_reset();
    push_pkt(2, 6, 32'h200, 6'd9);
    model_load();
    drive();
    n = 0;
    while (exp_q.size() > 4 && n < 20) begin step(); n++; end
    chk("stall_point", DATA_W'(exp_q.size()), DATA_W'(4));
    afull = 1'b1;
    repeat (5) step();
    afull = 1'b0;
    run(50);
    chk("pkt_cnt_stall", DATA_W'(pkt_cnt), DATA_W'(1));

    // Port 1 sends a beat without sop while idle, then a proper packet.
    do_reset();
    push_junk(1);
    push_pkt(1, 2, 32'h300, 6'd3);
    model_load();
    drive();
    run(50);
    chk("err_cnt_junk", DATA_W'(err_cnt), DATA_W'(1));
    chk("pkt_cnt_junk", DATA_W'(pkt_cnt), DATA_W'(1));

    // Simultaneous single-beat packets on ports 0 and 3.
    do_reset();
    push_pkt(3, 1, 32'h430, 6'd7);
    push_pkt(0, 1, 32'h400, 6'd5);
    model_load();
    drive();
    run(50);
    chk("pkt_cnt_single_beat", DATA_W'(pkt_cnt), DATA_W'(2));

    // Reset for one cycle in the middle of a packet; upstream is reset too.
    do_reset();
    push_pkt(2, 5, 32'h500, 6'd1);
    model_load();
    drive();
    n = 0;
    while (exp_q.size() > 3 && n < 20) begin step(); n++; end
    chk("rst_point", DATA_W'(exp_q.size()), DATA_W'(3));
    rst = 1'b1;
    for (int i = 0; i < NUM_IN; i++) srcq[i].delete();
    exp_q.delete();
    drive();
    step();
    rst = 1'b0;
    model_last = NUM_IN - 1;
    prev_afull = 1'b0;
    check_reset_state();
    push_pkt(2, 1, 32'h620, 6'd2);
    push_pkt(0, 1, 32'h600, 6'd0);
    model_load();
    drive();
    run(50);
    chk("pkt_cnt_after_rst", DATA_W'(pkt_cnt), DATA_W'(2));

    // Randomized traffic: random packet counts/lengths, valid gaps, almost_full.
    do_reset();
    rand_mode = 1'b1;
    total = 0;
    for (int round = 0; round < 3; round++) begin
      for (int p = 0; p < NUM_IN; p++) begin
        n = $urandom_range(1, 4);
        for (int k = 0; k < n; k++) push_rand_pkt(p);
        total += n;
      end
      model_load();
      drive();
      run(3000);
      chk("pkt_cnt_rand", DATA_W'(pkt_cnt), DATA_W'(total));
    end
    rand_mode = 1'b0;
    afull = 1'b0;
    step();
    chk("err_cnt_rand", DATA_W'(err_cnt), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
